// File: rtl/samp_scale_out.sv
// -----------------------------------------------------------------------------
// samp_scale_out
// -----------------------------------------------------------------------------
// Downstream consumer of the I/Q sample FIFO. Pops one sample per clock when
// the FIFO is non-empty, scales I and Q by a signed Q2.14 gain that travels
// with the sample, saturates each component to DW bits and presents the result
// on a PushOut/StopIn handshake.
//
// Pipeline (elastic, two stages):
//   stage 0 (fetch) : holds the popped sample and the gain captured with it
//   stage 1 (scale) : holds the scaled, saturated result; drives the outputs
// A sample popped at edge t is presented (PushOut = 1) after edge t+1.
// With StopIn low the block sustains one sample per clock.
//
// Optional feature macro:
//   SCALE_ROUND_EN  defined   -> round half up (add 2^(FRAC-1) before shift)
//                   undefined -> plain arithmetic shift (floor truncation)
//
// Ports:
//   Clk           in   1       rising-edge clock
//   Reset         in   1       asynchronous, active-high; clears all state
//   fifo_samp     in   2*DW    {I, Q} at the FIFO head (show-ahead)
//   fifo_empty    in   1       FIFO empty flag
//   fifo_PullOut  out  1       pop strobe to the FIFO (combinational)
//   Gain          in   GW      signed gain, captured with each popped sample
//   StopIn        in   1       downstream backpressure, high = hold
//   PushOut       out  1       output sample valid
//   SampOutI      out  DW      scaled, saturated I
//   SampOutQ      out  DW      scaled, saturated Q
//   sat_clr       in   1       synchronous clear of sat_flag
//   sat_flag      out  1       sticky saturation indicator
// -----------------------------------------------------------------------------
module samp_scale_out #(
  parameter int DW   = 24,
  parameter int GW   = 16,
  parameter int FRAC = 14
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [2*DW-1:0] fifo_samp,
  input  logic            fifo_empty,
  output logic            fifo_PullOut,
  input  logic [GW-1:0]   Gain,
  input  logic            StopIn,
  output logic            PushOut,
  output logic [DW-1:0]   SampOutI,
  output logic [DW-1:0]   SampOutQ,
  input  logic            sat_clr,
  output logic            sat_flag
);

  // Full product width: DW x GW signed needs DW+GW bits. One guard bit is
  // carried on top so the rounding add can never wrap.
  localparam int PW = DW + GW;

`ifdef SCALE_ROUND_EN
  // Half an LSB of the shifted result, i.e. 2^(FRAC-1).
  localparam logic signed [PW:0] RND = {{(PW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`endif

  // Scale one component: returns {clipped, saturated_value}.
  function automatic logic [DW:0] scale_sat(input logic [DW-1:0] s,
                                            input logic [GW-1:0] g);
    logic signed [PW:0]    s_x;
    logic signed [PW:0]    g_x;
    logic signed [PW:0]    p;
    logic signed [PW:0]    sh;
    logic [PW-DW+1:0]      top;
    logic [DW:0]           res;
    s_x = {{(GW+1){s[DW-1]}}, s};
    g_x = {{(DW+1){g[GW-1]}}, g};
    p   = s_x * g_x;
`ifdef SCALE_ROUND_EN
    p   = p + RND;
`endif
    sh  = p >>> FRAC;
    // The result fits in DW bits exactly when every bit from the DW-1 sign
    // position upward agrees; otherwise clip towards the true sign.
    top = sh[PW:DW-1];
    if ((&top) || !(|top)) begin
      res = {1'b0, sh[DW-1:0]};
    end else if (sh[PW]) begin
      res = {1'b1, 1'b1, {(DW-1){1'b0}}};
    end else begin
      res = {1'b1, 1'b0, {(DW-1){1'b1}}};
    end
    return res;
  endfunction

  // Stage 0 state
  logic            v0_r;
  logic [DW-1:0]   s0_i_r;
  logic [DW-1:0]   s0_q_r;
  logic [GW-1:0]   s0_g_r;

  // Stage 1 state (drives the outputs directly)
  logic            v1_r;
  logic [DW-1:0]   out_i_r;
  logic [DW-1:0]   out_q_r;
  logic            sat_r;

  // Handshake and datapath terms
  logic            mv1_s;
  logic            adv1_s;
  logic            pop_s;
  logic [DW:0]     res_i_s;
  logic [DW:0]     res_q_s;
  logic            clip_s;

  // Stage-move decisions and the scaling datapath for the sample in stage 0.
  always_comb begin
    mv1_s   = v1_r && !StopIn;
    adv1_s  = v0_r && (!v1_r || mv1_s);
    // The FIFO does not protect itself against pops on empty, and must not be
    // popped while it is itself being reset.
    pop_s   = !Reset && !fifo_empty && (!v0_r || adv1_s);
    res_i_s = scale_sat(s0_i_r, s0_g_r);
    res_q_s = scale_sat(s0_q_r, s0_g_r);
    clip_s  = res_i_s[DW] || res_q_s[DW];
  end

  // Stage 0: capture the FIFO head together with the current gain on a pop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v0_r   <= 1'b0;
      s0_i_r <= {DW{1'b0}};
      s0_q_r <= {DW{1'b0}};
      s0_g_r <= {GW{1'b0}};
    end else if (pop_s) begin
      v0_r   <= 1'b1;
      s0_i_r <= fifo_samp[2*DW-1:DW];
      s0_q_r <= fifo_samp[DW-1:0];
      s0_g_r <= Gain;
    end else if (adv1_s) begin
      v0_r   <= 1'b0;
    end else begin
      v0_r   <= v0_r;
    end
  end

  // Stage 1: register the scaled result; hold it while the consumer stalls.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1_r    <= 1'b0;
      out_i_r <= {DW{1'b0}};
      out_q_r <= {DW{1'b0}};
    end else if (adv1_s) begin
      v1_r    <= 1'b1;
      out_i_r <= res_i_s[DW-1:0];
      out_q_r <= res_q_s[DW-1:0];
    end else if (mv1_s) begin
      v1_r    <= 1'b0;
    end else begin
      v1_r    <= v1_r;
    end
  end

  // Sticky saturation flag: a clip entering stage 1 wins over a clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sat_r <= 1'b0;
    end else if (adv1_s && clip_s) begin
      sat_r <= 1'b1;
    end else if (sat_clr) begin
      sat_r <= 1'b0;
    end else begin
      sat_r <= sat_r;
    end
  end

  assign fifo_PullOut = pop_s;
  assign PushOut      = v1_r;
  assign SampOutI     = out_i_r;
  assign SampOutQ     = out_q_r;
  assign sat_flag     = sat_r;

endmodule

// File: tb/tb_samp_scale_out.sv
// -----------------------------------------------------------------------------
// tb_samp_scale_out
// -----------------------------------------------------------------------------
// Self-checking bench for samp_scale_out. A queue models the show-ahead FIFO
// (each entry carries its sample and the gain to apply), a second queue holds
// the expected outputs in order. Expected values come from a vector table for
// the directed cases and from an arithmetic reference model for random traffic.
// Inputs change 1 time unit after the rising edge; outputs are observed on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_samp_scale_out;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [47:0] fifo_samp;
  logic        fifo_empty;
  logic        fifo_PullOut;
  logic [15:0] Gain;
  logic        StopIn;
  logic        PushOut;
  logic [23:0] SampOutI;
  logic [23:0] SampOutQ;
  logic        sat_clr;
  logic        sat_flag;

  samp_scale_out dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .fifo_samp    (fifo_samp),
    .fifo_empty   (fifo_empty),
    .fifo_PullOut (fifo_PullOut),
    .Gain         (Gain),
    .StopIn       (StopIn),
    .PushOut      (PushOut),
    .SampOutI     (SampOutI),
    .SampOutQ     (SampOutQ),
    .sat_clr      (sat_clr),
    .sat_flag     (sat_flag)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [23:0] i; logic [23:0] q; logic [15:0] g; } in_t;
  typedef struct { logic [23:0] i; logic [23:0] q; bit clip; } exp_t;
  typedef struct {
    logic [23:0] i; logic [23:0] q; logic [15:0] g;
    logic [23:0] ei; logic [23:0] eq; bit clip;
  } vec_t;

  in_t  fifo_q[$];
  exp_t exp_q[$];
  vec_t vecs[7];

  int n_chk  = 0;
  int n_pass = 0;

  bit          model_sat  = 1'b0;
  bit          front_seen = 1'b0;
  bit          prev_hold  = 1'b0;
  logic [23:0] held_i, held_q;

  task automatic check24(input string name, input logic [23:0] act, input logic [23:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, req);
  endtask

  // Reference: one component, full-precision product, optional round, floor shift, clamp.
  function automatic logic [24:0] ref_comp(input logic [23:0] s, input logic [15:0] g);
    longint p, r;
    bit     c;
    p = longint'($signed(s)) * longint'($signed(g));
`ifdef SCALE_ROUND_EN
    p = p + 64'sd8192;
`endif
    r = p >>> 14;
    c = 1'b1;
    if (r > 64'sd8388607) r = 64'sd8388607;
    else if (r < -64'sd8388608) r = -64'sd8388608;
    else c = 1'b0;
    return {c, r[23:0]};
  endfunction

  function automatic exp_t ref_model(input in_t x);
    exp_t e;
    logic [24:0] ri, rq;
    ri = ref_comp(x.i, x.g);
    rq = ref_comp(x.q, x.g);
    e.i = ri[23:0];
    e.q = rq[23:0];
    e.clip = ri[24] | rq[24];
    return e;
  endfunction

  task automatic drive();
    if (fifo_q.size() != 0) begin
      fifo_samp  = {fifo_q[0].i, fifo_q[0].q};
      Gain       = fifo_q[0].g;
      fifo_empty = 1'b0;
    end else begin
      fifo_samp  = {$urandom, $urandom};
      Gain       = 16'($urandom);
      fifo_empty = 1'b1;
    end
  endtask

  task automatic push(input in_t x, input exp_t e);
    fifo_q.push_back(x);
    exp_q.push_back(e);
    drive();
  endtask

  task automatic push_rand(input bit big_gain);
    in_t x;
    x.i = 24'($urandom);
    x.q = 24'($urandom);
    x.g = big_gain ? 16'($urandom) : 16'($urandom_range(0, 16'h4000));
    push(x, ref_model(x));
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    model_sat  = 1'b0;
    front_seen = 1'b0;
    prev_hold  = 1'b0;
    drive();
  endtask

  // One clock: observe on the falling edge, then update the FIFO model after the rising edge.
  task automatic tick();
    bit pull;
    @(negedge Clk);
    if (prev_hold) begin
      check1("hold_push", PushOut, 1'b1);
      check24("hold_i", SampOutI, held_i);
      check24("hold_q", SampOutQ, held_q);
    end
    if (PushOut && !front_seen && exp_q.size() != 0) begin
      front_seen = 1'b1;
      if (exp_q[0].clip) model_sat = 1'b1;
    end
    check1("sat_flag", sat_flag, model_sat);
    if (PushOut && !StopIn) begin
      if (exp_q.size() == 0) begin
        check1("unexpected_out", 1'b1, 1'b0);
      end else begin
        check24("out_i", SampOutI, exp_q[0].i);
        check24("out_q", SampOutQ, exp_q[0].q);
        void'(exp_q.pop_front());
        front_seen = 1'b0;
      end
    end
    prev_hold = PushOut && StopIn;
    held_i    = SampOutI;
    held_q    = SampOutQ;
    pull      = fifo_PullOut;
    check1("pull_on_empty", pull && fifo_empty, 1'b0);
    @(posedge Clk);
    #1;
    if (pull && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (sat_clr) model_sat = 1'b0;
    drive();
  endtask

  task automatic drain(input string name);
    int b = 0;
    while (exp_q.size() != 0 && b < 60) begin
      tick();
      b++;
    end
    check1({name, "_drained"}, exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    int first_po, last_po, n_po;
    int b;

    // i, q, gain, expected i, expected q, clip
    vecs[0] = '{24'h100000, 24'hF00000, 16'h4000, 24'h100000, 24'hF00000, 1'b0};
    vecs[1] = '{24'h600000, 24'hA00000, 16'h7FFF, 24'h7FFFFF, 24'h800000, 1'b1};
`ifdef SCALE_ROUND_EN
    vecs[2] = '{24'hFFFFFD, 24'h000003, 16'h2000, 24'hFFFFFF, 24'h000002, 1'b0};
`else
    vecs[2] = '{24'hFFFFFD, 24'h000003, 16'h2000, 24'hFFFFFE, 24'h000001, 1'b0};
`endif
    vecs[3] = '{24'h000001, 24'hFFFFFF, 16'h8000, 24'hFFFFFE, 24'h000002, 1'b0};
    vecs[4] = '{24'h7FFFFF, 24'h800000, 16'h8000, 24'h800000, 24'h7FFFFF, 1'b1};
    vecs[5] = '{24'h123456, 24'hABCDEF, 16'h0000, 24'h000000, 24'h000000, 1'b0};
    vecs[6] = '{24'h200000, 24'hE00000, 16'h2000, 24'h100000, 24'hF00000, 1'b0};

    // Reset state; a non-empty FIFO must still not be popped while Reset is high.
    Reset = 1'b1; StopIn = 1'b0; sat_clr = 1'b0;
    fifo_q.push_back('{24'h111111, 24'h222222, 16'h4000});
    drive();
    #1;
    check1("rst_pull", fifo_PullOut, 1'b0);
    check1("rst_push", PushOut, 1'b0);
    check24("rst_i", SampOutI, 24'h0);
    check24("rst_q", SampOutQ, 24'h0);
    check1("rst_sat", sat_flag, 1'b0);
    repeat (3) @(posedge Clk);
    #1;
    clear_model();
    Reset = 1'b0;
    tick();

    // Latency: pop at edge t, PushOut visible after edge t+1.
    push('{vecs[0].i, vecs[0].q, vecs[0].g}, '{vecs[0].ei, vecs[0].eq, vecs[0].clip});
    tick();
    check1("lat_t", PushOut, 1'b0);
    tick();
    check1("lat_t1", PushOut, 1'b1);
    drain("unity");

    // Vector table: each entry alone, then check and clear the sticky flag.
    for (int k = 0; k < 7; k++) begin
      push('{vecs[k].i, vecs[k].q, vecs[k].g}, '{vecs[k].ei, vecs[k].eq, vecs[k].clip});
      drain("vec");
      check1("vec_sat", sat_flag, vecs[k].clip);
      sat_clr = 1'b1;
      tick();
      sat_clr = 1'b0;
      check1("sat_clr", sat_flag, 1'b0);
    end

    // Streaming: 4 samples in 4 consecutive PushOut cycles.
    for (int k = 0; k < 4; k++) push_rand(1'b0);
    first_po = -1; last_po = -1; n_po = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (PushOut) begin
        if (first_po < 0) first_po = c;
        last_po = c;
        n_po++;
      end
    end
    check24("stream_count", 24'(n_po), 24'd4);
    check24("stream_span", 24'(last_po - first_po + 1), 24'd4);
    check1("stream_empty", exp_q.size() == 0, 1'b1);

    // Backpressure: 6 samples, StopIn high for 5 clocks from the first PushOut.
    for (int k = 0; k < 6; k++) push_rand(1'b1);
    b = 0;
    while (!PushOut && b < 10) begin
      tick();
      b++;
    end
    check1("bp_first_push", PushOut, 1'b1);
    StopIn = 1'b1;
    repeat (5) tick();
    #1;
    check1("bp_pull_low", fifo_PullOut, 1'b0);
    check1("bp_fifo_left", fifo_empty, 1'b0);
    StopIn = 1'b0;
    drain("bp");

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 6 && fifo_q.size() < 8) push_rand($urandom_range(0, 1) == 1);
      StopIn  = ($urandom_range(0, 3) == 0);
      sat_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    StopIn = 1'b0; sat_clr = 1'b0;
    drain("rand");

    // Reset mid-stream with both stages full and sat_flag set.
    push('{24'h600000, 24'h000010, 16'h7FFF}, ref_model('{24'h600000, 24'h000010, 16'h7FFF}));
    for (int k = 0; k < 3; k++) push_rand(1'b0);
    StopIn = 1'b1;
    b = 0;
    while (!PushOut && b < 10) begin
      tick();
      b++;
    end
    tick();
    tick();
    check1("mid_pre_sat", sat_flag, 1'b1);
    Reset = 1'b1;
    #1;
    check1("mid_push", PushOut, 1'b0);
    check24("mid_i", SampOutI, 24'h0);
    check24("mid_q", SampOutQ, 24'h0);
    check1("mid_sat", sat_flag, 1'b0);
    check1("mid_pull", fifo_PullOut, 1'b0);
    clear_model();
    StopIn = 1'b0;
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check1("post_rst_idle", PushOut, 1'b0);
    end
    push('{24'h000100, 24'hFFFF00, 16'h4000}, '{24'h000100, 24'hFFFF00, 1'b0});
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
